// File: rtl/depp_mailbox_pkg.sv
`default_nettype none
// ============================================================================
// Module      : depp_mailbox_pkg
// Description : Register map, bit positions and defaults for depp_mailbox.
// Revision    : 1.0 - initial release
// ============================================================================
package depp_mailbox_pkg;

    localparam logic [7:0] ADDR_ID       = 8'h00;
    localparam logic [7:0] ADDR_CTRL     = 8'h01;
    localparam logic [7:0] ADDR_STATUS   = 8'h02;
    localparam logic [7:0] ADDR_TX_COUNT = 8'h03;
    localparam logic [7:0] ADDR_TX_DATA  = 8'h04;
    localparam logic [7:0] ADDR_RX_DATA  = 8'h05;
    localparam logic [7:0] ADDR_RX_ACK   = 8'h06;
    localparam logic [7:0] ADDR_ERR_CLR  = 8'h07;
    localparam logic [7:0] ADDR_SCRATCH0 = 8'h08;
    localparam logic [7:0] ADDR_SCRATCH7 = 8'h0F;

    localparam int CTRL_TX_EN    = 0;
    localparam int CTRL_FLUSH    = 1;

    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_RX_FULL  = 2;
    localparam int STAT_TX_OVF   = 3;
    localparam int STAT_TX_EN    = 4;

    localparam logic [7:0] DEFAULT_ID = 8'hA5;

    // Scratch bytes occupy the aligned 8-byte window starting at 0x08.
    function automatic logic is_scratch(input logic [7:0] a);
        return (a[7:3] == ADDR_SCRATCH0[7:3]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/depp_mailbox_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word fall-through FIFO with flush.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush && !rst) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign empty = (r_count == '0);
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign count = r_count;
    assign head  = empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/depp_mailbox.sv
`default_nettype none
// ============================================================================
// Module      : depp_mailbox
// Description : DEPP register/mailbox block: TX FIFO stream out, RX byte in.
// Revision    : 1.0 - initial release
// ============================================================================
module depp_mailbox
    import depp_mailbox_pkg::*;
#(
    parameter int         TX_DEPTH = 16,
    parameter logic [7:0] ID_VAL   = DEFAULT_ID
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    input  logic       rx_in_valid,
    input  logic [7:0] rx_in_data,
    output logic       rx_in_ready
);

    localparam int CW = $clog2(TX_DEPTH) + 1;

    logic         r_tx_en;
    logic         r_tx_ovf;
    logic         r_rx_full;
    logic [7:0]   r_rx_data;
    logic [7:0]   r_scratch [8];

    logic         w_wr_ctrl;
    logic         w_wr_txdata;
    logic         w_wr_rxack;
    logic         w_wr_errclr;
    logic         w_wr_scratch;
    logic         w_flush;
    logic         w_pop;
    logic         w_rx_take;
    logic         w_fifo_empty;
    logic         w_fifo_full;
    logic [7:0]   w_fifo_head;
    logic [CW-1:0] w_fifo_count;
    logic [7:0]   w_status;

    assign w_wr_ctrl    = we && (addr == ADDR_CTRL);
    assign w_wr_txdata  = we && (addr == ADDR_TX_DATA);
    assign w_wr_rxack   = we && (addr == ADDR_RX_ACK);
    assign w_wr_errclr  = we && (addr == ADDR_ERR_CLR);
    assign w_wr_scratch = we && is_scratch(addr);
    assign w_flush      = w_wr_ctrl && din[CTRL_FLUSH];

    assign tx_valid    = ~w_fifo_empty & r_tx_en;
    assign tx_data     = w_fifo_head;
    assign w_pop       = tx_valid & tx_ready;
    assign rx_in_ready = ~r_rx_full;
    assign w_rx_take   = rx_in_valid & ~r_rx_full;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (w_flush),
        .push      (w_wr_txdata),
        .push_data (din),
        .pop       (w_pop),
        .head      (w_fifo_head),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full),
        .count     (w_fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_en   <= 1'b0;
            r_tx_ovf  <= 1'b0;
            r_rx_full <= 1'b0;
            r_rx_data <= 8'h00;
            for (int i = 0; i < 8; i++) r_scratch[i] <= 8'h00;
        end else begin
            if (w_wr_ctrl) r_tx_en <= din[CTRL_TX_EN];

            // A rejected push outranks a simultaneous clear.
            if (w_wr_txdata && w_fifo_full) r_tx_ovf <= 1'b1;
            else if (w_wr_errclr)           r_tx_ovf <= 1'b0;

            // rx_in_ready was 0 whenever an ack can matter, so capture and ack never collide on a full mailbox.
            if (w_rx_take) begin
                r_rx_data <= rx_in_data;
                r_rx_full <= 1'b1;
            end else if (w_wr_rxack) begin
                r_rx_full <= 1'b0;
            end

            if (w_wr_scratch) r_scratch[addr[2:0]] <= din;
        end
    end

    always_comb begin
        w_status                = 8'h00;
        w_status[STAT_TX_FULL]  = w_fifo_full;
        w_status[STAT_TX_EMPTY] = w_fifo_empty;
        w_status[STAT_RX_FULL]  = r_rx_full;
        w_status[STAT_TX_OVF]   = r_tx_ovf;
        w_status[STAT_TX_EN]    = r_tx_en;
    end

    always_comb begin
        dout = 8'h00;
        if (is_scratch(addr)) begin
            dout = r_scratch[addr[2:0]];
        end else begin
            case (addr)
                ADDR_ID:       dout = ID_VAL;
                ADDR_CTRL:     dout = {7'b0, r_tx_en};
                ADDR_STATUS:   dout = w_status;
                ADDR_TX_COUNT: dout = 8'(w_fifo_count);
                ADDR_RX_DATA:  dout = r_rx_data;
                default:       dout = 8'h00;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/depp_mailbox.md
Name: depp_mailbox

Overview:
- Memory-mapped register/mailbox block that sits directly downstream of the DEPP-to-memory bridge.
- Consumes the bridge's single-cycle write strobe, 8-bit address and write data; returns read data combinationally on the same address.
- Host writes are buffered in a TX FIFO and drained by fabric logic over a valid/ready stream.
- Fabric logic posts single bytes to the host through an RX mailbox register.

Parameters:
- TX_DEPTH, 16, TX FIFO entries; power of two, 2..128.
- ID_VAL, 8'hA5, constant returned at address 0x00.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- we  input  1  write enable from bridge, active high, one clk per host write.
- addr  input  8  register address; held stable between host transactions.
- din  input  8  write data, valid when we=1.
- dout  output  8  read data for addr; combinational from addr and registered state.
- tx_valid  output  1  TX FIFO head valid (first-word fall-through).
- tx_data  output  8  TX FIFO head byte.
- tx_ready  input  1  consumer accepts head when tx_valid & tx_ready.
- rx_in_valid  input  1  fabric offers a byte to the mailbox.
- rx_in_data  input  8  mailbox byte.
- rx_in_ready  output  1  = ~rx_full; byte is captured when rx_in_valid & rx_in_ready.

Behaviour:
- Register map; any unlisted address reads 8'h00 and ignores writes:
  - 0x00 ID, RO, ID_VAL.
  - 0x01 CTRL, RW. bit0 tx_en. bit1 flush: write-1 pulse, self-clears, always reads 0. Other bits read 0.
  - 0x02 STATUS, RO. bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 tx_overflow (sticky), bit4 tx_en echo, bits7:5 read 0.
  - 0x03 TX_COUNT, RO, occupancy 0..TX_DEPTH. TX_DEPTH=128 reads 8'h80.
  - 0x04 TX_DATA, WO. Write pushes din; reads 0.
  - 0x05 RX_DATA, RO. Mailbox byte; reads have no side effect.
  - 0x06 RX_ACK, WO. Any write clears rx_full.
  - 0x07 ERR_CLR, WO. Any write clears tx_overflow.
  - 0x08..0x0F SCRATCH0..7, RW plain bytes.
- Reset values:
  - tx_en=0, FIFO empty, tx_overflow=0, rx_full=0, RX_DATA=0, scratch=0.
  - Outputs: tx_valid=0, tx_data=0, rx_in_ready=1; dout reflects reset state.
- Write timing: a register write is visible on dout in the cycle after the we cycle.
- Reads: no read strobe exists, so no read may have side effects.
- TX push: on we & addr==0x04.
  - Accepted iff count<TX_DEPTH at the start of the cycle; a pop in the same cycle does not make room.
  - A rejected push sets tx_overflow; data is discarded and FIFO contents are unchanged.
- TX pop: when tx_valid & tx_ready.
  - tx_valid = ~empty & tx_en. tx_data = head entry (0 when empty).
  - Clearing tx_en stalls draining; contents are kept.
- Simultaneous push and pop with 0<count<TX_DEPTH: count unchanged; order preserved.
- Flush: CTRL write with bit1=1.
  - Next cycle count=0 and pointers are reset.
  - Flush wins over a same-cycle push or pop; tx_overflow is unaffected.
  - tx_en takes din[0] in the same write.
- Pointers: log2(TX_DEPTH)-bit wrap-around; separate count register is log2(TX_DEPTH)+1 bits.
- RX mailbox:
  - On rx_in_valid & ~rx_full: capture rx_in_data, set rx_full.
  - RX_ACK write and an incoming byte in the same cycle: ack clears rx_full; the byte is not taken that cycle (ready was 0) and is captured the next cycle.
- tx_overflow: set and ERR_CLR in the same cycle leaves it set (set wins).
- Reset asserted mid-operation: all state returns to reset values on the next edge; an in-flight push or pop is lost.

Decomposition:
- Package depp_mailbox_pkg: address constants for 0x00..0x0F, CTRL/STATUS bit indices, DEFAULT_ID.
- Sub-module sync_fifo (params WIDTH=8, DEPTH), first-word fall-through.
  - Ports: clk, rst, flush, push, push_data, pop, head, empty, full, count.
- depp_mailbox contains address decode, registers, overflow logic, mailbox and the read mux.

Test Plan:
- Reset then read 0x00,0x02,0x03 -> 8'hA5, 8'h02, 8'h00; rx_in_ready=1, tx_valid=0.
- Write CTRL=0x01; push 0x11,0x22,0x33 to 0x04 with tx_ready=1 -> tx_data sequence 11,22,33, each for one cycle; TX_COUNT ends 0.
- tx_en=0; push 17 bytes with TX_DEPTH=16 -> TX_COUNT=16; STATUS=0x09 (full, overflow). ERR_CLR -> 0x01. Enable and drain -> first 16 bytes in order.
- FIFO at 5 entries, CTRL write 0x03 in the same cycle as tx_ready=1 -> next cycle TX_COUNT=0, tx_valid=0; CTRL reads 0x01.
- rx_in_valid with 0x5A -> RX_DATA=0x5A, STATUS bit2=1, rx_in_ready=0. Hold 0x6B offered; RX_ACK write -> 0x6B captured one cycle later.
- Write SCRATCH3=0xC3 then read 0x0B -> 0xC3; read 0x20 -> 0x00; write 0x20 -> no state change.
